// File: rtl/ecc_scrub_ctrl.sv
// ECC memory scrubber: walks an address range, writes back corrected words,
// counts single/multiple errors and logs uncorrectable addresses in a small FIFO.
module ecc_scrub_ctrl #(
    parameter int ADDR_W    = 14,
    parameter int DATA_W    = 64,
    parameter int LOG_DEPTH = 4,
    parameter int CNT_W     = 16
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              START,
    input  logic              ABORT,
    input  logic [ADDR_W-1:0] ADDR_LO,
    input  logic [ADDR_W-1:0] ADDR_HI,
    output logic              R_EN,
    output logic [ADDR_W-1:0] R_ADDR,
    input  logic [DATA_W-1:0] RD_DATA,
    input  logic              SB_CORRECT,
    input  logic              DB_DETECT,
    output logic              W_EN,
    output logic [ADDR_W-1:0] W_ADDR,
    output logic [DATA_W-1:0] W_DATA,
    output logic              BUSY,
    output logic              DONE,
    output logic [CNT_W-1:0]  SB_COUNT,
    output logic [CNT_W-1:0]  DB_COUNT,
    output logic              LOG_VALID,
    output logic [ADDR_W-1:0] LOG_ADDR,
    input  logic              LOG_POP,
    output logic              LOG_OVF
);

    localparam int PTR_W  = (LOG_DEPTH > 1) ? $clog2(LOG_DEPTH) : 1;
    localparam int LCNT_W = $clog2(LOG_DEPTH + 1);

    typedef enum logic [2:0] {IDLE, READ, WAIT, CHECK, WRITE, NEXT, FIN} state_t;

    state_t             r_state;
    state_t             w_nextState;
    logic [ADDR_W-1:0]  r_addrHi;
    logic [ADDR_W-1:0]  r_curAddr;
    logic [DATA_W-1:0]  r_rdData;
    logic               r_sbFlag;
    logic               r_dbFlag;
    logic [CNT_W-1:0]   r_sbCount;
    logic [CNT_W-1:0]   r_dbCount;
    logic               r_logOvf;
    logic [ADDR_W-1:0]  r_logMem [LOG_DEPTH];
    logic [PTR_W-1:0]   r_wrPtr;
    logic [PTR_W-1:0]   r_rdPtr;
    logic [LCNT_W-1:0]  r_logCount;

    logic w_startOk;
    logic w_singleErr;
    logic w_multiErr;
    logic w_logEmpty;
    logic w_logFull;
    logic w_push;
    logic w_pushOk;
    logic w_pop;

    function automatic logic [PTR_W-1:0] ptrInc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(LOG_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign w_startOk   = (r_state == IDLE) && START && (ADDR_LO <= ADDR_HI);
    assign w_singleErr = r_sbFlag && !r_dbFlag;
    assign w_multiErr  = r_sbFlag && r_dbFlag;
    assign w_logEmpty  = (r_logCount == '0);
    assign w_logFull   = (r_logCount == LCNT_W'(LOG_DEPTH));
    assign w_push      = (r_state == CHECK) && !ABORT && w_multiErr;
    assign w_pop       = LOG_POP && !w_logEmpty;
    // A full log still accepts a push when the head is popped in the same cycle.
    assign w_pushOk    = w_push && (!w_logFull || w_pop);

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE:    if (w_startOk) w_nextState = READ;
            READ:    w_nextState = ABORT ? IDLE : WAIT;
            WAIT:    w_nextState = ABORT ? IDLE : CHECK;
            CHECK:   w_nextState = ABORT ? IDLE : (w_singleErr ? WRITE : NEXT);
            WRITE:   w_nextState = ABORT ? IDLE : NEXT;
            NEXT:    w_nextState = ABORT ? IDLE :
                                   ((r_curAddr == r_addrHi) ? FIN : READ);
            FIN:     w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state    <= IDLE;
            r_addrHi   <= '0;
            r_curAddr  <= '0;
            r_rdData   <= '0;
            r_sbFlag   <= 1'b0;
            r_dbFlag   <= 1'b0;
            r_sbCount  <= '0;
            r_dbCount  <= '0;
            r_logOvf   <= 1'b0;
            r_wrPtr    <= '0;
            r_rdPtr    <= '0;
            r_logCount <= '0;
        end else begin
            r_state <= w_nextState;
            if (w_startOk) begin
                r_addrHi  <= ADDR_HI;
                r_curAddr <= ADDR_LO;
                r_sbCount <= '0;
                r_dbCount <= '0;
                r_logOvf  <= 1'b0;
            end
            if (r_state == WAIT && !ABORT) begin
                r_rdData <= RD_DATA;
                r_sbFlag <= SB_CORRECT;
                r_dbFlag <= DB_DETECT;
            end
            if (r_state == CHECK && !ABORT) begin
                if (w_singleErr && r_sbCount != {CNT_W{1'b1}})
                    r_sbCount <= r_sbCount + 1'b1;
                if (w_multiErr && r_dbCount != {CNT_W{1'b1}})
                    r_dbCount <= r_dbCount + 1'b1;
            end
            // Equality-only termination keeps the top address from wrapping.
            if (r_state == NEXT && !ABORT && r_curAddr != r_addrHi)
                r_curAddr <= r_curAddr + 1'b1;
            if (w_pushOk)
                r_wrPtr <= ptrInc(r_wrPtr);
            if (w_push && !w_pushOk)
                r_logOvf <= 1'b1;
            if (w_pop)
                r_rdPtr <= ptrInc(r_rdPtr);
            case ({w_pushOk, w_pop})
                2'b10:   r_logCount <= r_logCount + LCNT_W'(1);
                2'b01:   r_logCount <= r_logCount - LCNT_W'(1);
                default: r_logCount <= r_logCount;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST && w_pushOk)
            r_logMem[r_wrPtr] <= r_curAddr;
    end

    assign R_EN      = (r_state == READ);
    assign R_ADDR    = R_EN ? r_curAddr : '0;
    assign W_EN      = (r_state == WRITE);
    assign W_ADDR    = W_EN ? r_curAddr : '0;
    assign W_DATA    = W_EN ? r_rdData : '0;
    assign BUSY      = (r_state != IDLE);
    assign DONE      = (r_state == FIN);
    assign SB_COUNT  = r_sbCount;
    assign DB_COUNT  = r_dbCount;
    assign LOG_VALID = !w_logEmpty;
    assign LOG_ADDR  = LOG_VALID ? r_logMem[r_rdPtr] : '0;
    assign LOG_OVF   = r_logOvf;

endmodule

// File: tb/tb_ecc_scrub_ctrl.sv
// Directed bench for ecc_scrub_ctrl: a tiny memory model answers reads from
// per-address error masks, and each step checks outputs with immediate assertions.
module tb_ecc_scrub_ctrl;

    logic        CLK = 1'b0;
    logic        RST, START, ABORT, LOG_POP;
    logic [13:0] ADDR_LO, ADDR_HI;
    logic        R_EN, W_EN, BUSY, DONE, LOG_VALID, LOG_OVF;
    logic [13:0] R_ADDR, W_ADDR, LOG_ADDR;
    logic [63:0] RD_DATA, W_DATA;
    logic        SB_CORRECT, DB_DETECT;
    logic [15:0] SB_COUNT, DB_COUNT;

    int vectors = 0;
    int miscompares = 0;

    int          cycle = 0;
    logic        prevREn = 1'b0;
    logic [13:0] prevAddr = '0;
    logic [15:0] sbLow = '0;
    logic [15:0] dbLow = '0;
    logic [13:0] rAddrs[$];
    int          rCycles[$];
    int          wCount, doneCount, doneCycle;
    logic [13:0] wAddrLast;
    logic [63:0] wDataLast;
    logic        bothSeen;
    logic        timedOut;

    ecc_scrub_ctrl #(.ADDR_W(14), .DATA_W(64), .LOG_DEPTH(4), .CNT_W(16)) dut (
        .CLK(CLK), .RST(RST), .START(START), .ABORT(ABORT),
        .ADDR_LO(ADDR_LO), .ADDR_HI(ADDR_HI),
        .R_EN(R_EN), .R_ADDR(R_ADDR), .RD_DATA(RD_DATA),
        .SB_CORRECT(SB_CORRECT), .DB_DETECT(DB_DETECT),
        .W_EN(W_EN), .W_ADDR(W_ADDR), .W_DATA(W_DATA),
        .BUSY(BUSY), .DONE(DONE), .SB_COUNT(SB_COUNT), .DB_COUNT(DB_COUNT),
        .LOG_VALID(LOG_VALID), .LOG_ADDR(LOG_ADDR), .LOG_POP(LOG_POP),
        .LOG_OVF(LOG_OVF)
    );

    always #5 CLK = ~CLK;

    function automatic logic [63:0] memData(input logic [13:0] a);
        return (a == 14'd4) ? 64'hA5A5 : {48'hDEAD_BEEF_0000, 2'b00, a};
    endfunction

    function automatic logic [13:0] rAddrAt(input int i);
        return (i < rAddrs.size()) ? rAddrs[i] : 14'h3FFF;
    endfunction

    function automatic int rCycleAt(input int i);
        return (i < rCycles.size()) ? rCycles[i] : -1000;
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // One clock: sample just after the edge, record events, and answer the
    // read issued in the previous cycle so the data is valid during WAIT.
    task automatic tick();
        @(posedge CLK);
        #1;
        cycle++;
        if (prevREn) begin
            RD_DATA    = memData(prevAddr);
            SB_CORRECT = (prevAddr < 14'd16) ? sbLow[prevAddr[3:0]] : 1'b0;
            DB_DETECT  = (prevAddr < 14'd16) ? dbLow[prevAddr[3:0]] : 1'b0;
        end else begin
            RD_DATA    = '0;
            SB_CORRECT = 1'b0;
            DB_DETECT  = 1'b0;
        end
        prevREn  = R_EN;
        prevAddr = R_ADDR;
        if (R_EN) begin
            rAddrs.push_back(R_ADDR);
            rCycles.push_back(cycle);
        end
        if (W_EN) begin
            wCount++;
            wAddrLast = W_ADDR;
            wDataLast = W_DATA;
        end
        if (DONE) begin
            doneCount++;
            doneCycle = cycle;
        end
        if (R_EN && W_EN) bothSeen = 1'b1;
    endtask

    task automatic clearTrack();
        rAddrs.delete();
        rCycles.delete();
        wCount    = 0;
        doneCount = 0;
        doneCycle = -1000;
        wAddrLast = '0;
        wDataLast = '0;
    endtask

    task automatic applyStimulus(input logic [13:0] lo, input logic [13:0] hi);
        clearTrack();
        ADDR_LO = lo;
        ADDR_HI = hi;
        START   = 1'b1;
        tick();
        START   = 1'b0;
    endtask

    task automatic runToIdle();
        timedOut = 1'b1;
        for (int n = 0; n < 200; n++) begin
            if (!BUSY) begin
                timedOut = 1'b0;
                break;
            end
            tick();
        end
    endtask

    initial begin
        RST = 1'b1; START = 1'b0; ABORT = 1'b0; LOG_POP = 1'b0;
        ADDR_LO = '0; ADDR_HI = '0;
        RD_DATA = '0; SB_CORRECT = 1'b0; DB_DETECT = 1'b0;
        bothSeen = 1'b0;
        clearTrack();
        repeat (3) tick();
        RST = 1'b0;
        tick();
        $display("[TB] reset state");
        checkOutput("rst_busy",     BUSY,      0);
        checkOutput("rst_ren",      R_EN,      0);
        checkOutput("rst_wen",      W_EN,      0);
        checkOutput("rst_done",     DONE,      0);
        checkOutput("rst_logvalid", LOG_VALID, 0);
        checkOutput("rst_sbcount",  SB_COUNT,  0);
        checkOutput("rst_dbcount",  DB_COUNT,  0);
        checkOutput("rst_logovf",   LOG_OVF,   0);
        checkOutput("rst_raddr",    R_ADDR,    0);
        checkOutput("rst_wdata",    W_DATA,    0);

        $display("[TB] clean scrub 3..5");
        sbLow = '0; dbLow = '0;
        applyStimulus(14'd3, 14'd5);
        runToIdle();
        checkOutput("clean_timeout", timedOut, 0);
        checkOutput("clean_nreads",  rAddrs.size(), 3);
        checkOutput("clean_addr0",   rAddrAt(0), 3);
        checkOutput("clean_addr1",   rAddrAt(1), 4);
        checkOutput("clean_addr2",   rAddrAt(2), 5);
        checkOutput("clean_gap01",   64'(rCycleAt(1) - rCycleAt(0)), 4);
        checkOutput("clean_gap12",   64'(rCycleAt(2) - rCycleAt(1)), 4);
        checkOutput("clean_nwrites", wCount, 0);
        checkOutput("clean_ndone",   doneCount, 1);
        checkOutput("clean_donelat", 64'(doneCycle - rCycleAt(0)), 12);
        checkOutput("clean_sbcount", SB_COUNT, 0);
        checkOutput("clean_dbcount", DB_COUNT, 0);

        $display("[TB] single error at 4");
        sbLow = 16'h0010; dbLow = '0;
        applyStimulus(14'd3, 14'd5);
        runToIdle();
        checkOutput("sb_timeout", timedOut, 0);
        checkOutput("sb_nwrites", wCount, 1);
        checkOutput("sb_waddr",   wAddrLast, 4);
        checkOutput("sb_wdata",   wDataLast, 64'hA5A5);
        checkOutput("sb_sbcount", SB_COUNT, 1);
        checkOutput("sb_dbcount", DB_COUNT, 0);
        checkOutput("sb_donelat", 64'(doneCycle - rCycleAt(0)), 13);

        $display("[TB] multiple errors 1..6, log overflow");
        sbLow = 16'h007E; dbLow = 16'h007E;
        applyStimulus(14'd1, 14'd6);
        runToIdle();
        checkOutput("db_timeout",  timedOut, 0);
        checkOutput("db_dbcount",  DB_COUNT, 6);
        checkOutput("db_sbcount",  SB_COUNT, 0);
        checkOutput("db_nwrites",  wCount, 0);
        checkOutput("db_logovf",   LOG_OVF, 1);
        for (int i = 0; i < 4; i++) begin
            checkOutput($sformatf("db_logvalid%0d", i), LOG_VALID, 1);
            checkOutput($sformatf("db_logaddr%0d", i), LOG_ADDR, 64'(i + 1));
            LOG_POP = 1'b1;
            tick();
            LOG_POP = 1'b0;
        end
        checkOutput("db_logempty", LOG_VALID, 0);
        LOG_POP = 1'b1;
        tick();
        LOG_POP = 1'b0;
        checkOutput("db_popempty", LOG_VALID, 0);
        checkOutput("db_ovfsticky", LOG_OVF, 1);

        $display("[TB] top address 3FFF");
        sbLow = '0; dbLow = '0;
        applyStimulus(14'h3FFF, 14'h3FFF);
        runToIdle();
        checkOutput("top_timeout", timedOut, 0);
        checkOutput("top_nreads",  rAddrs.size(), 1);
        checkOutput("top_addr",    rAddrAt(0), 14'h3FFF);
        checkOutput("top_ndone",   doneCount, 1);
        checkOutput("top_donelat", 64'(doneCycle - rCycleAt(0)), 4);
        checkOutput("top_ovfclr",  LOG_OVF, 0);

        $display("[TB] abort in WAIT");
        sbLow = 16'h0008; dbLow = '0;
        applyStimulus(14'd3, 14'd5);
        tick();
        ABORT = 1'b1;
        tick();
        ABORT = 1'b0;
        checkOutput("abw_busy", BUSY, 0);
        repeat (5) tick();
        checkOutput("abw_ndone",   doneCount, 0);
        checkOutput("abw_nwrites", wCount, 0);
        checkOutput("abw_nreads",  rAddrs.size(), 1);
        checkOutput("abw_sbcount", SB_COUNT, 0);

        $display("[TB] abort in WRITE");
        applyStimulus(14'd3, 14'd5);
        repeat (3) tick();
        checkOutput("abwr_wen", W_EN, 1);
        ABORT = 1'b1;
        tick();
        ABORT = 1'b0;
        checkOutput("abwr_busy", BUSY, 0);
        repeat (5) tick();
        checkOutput("abwr_nwrites", wCount, 1);
        checkOutput("abwr_waddr",   wAddrLast, 3);
        checkOutput("abwr_wdata",   wDataLast, 64'hDEADBEEF00000003);
        checkOutput("abwr_ndone",   doneCount, 0);
        checkOutput("abwr_nreads",  rAddrs.size(), 1);
        checkOutput("abwr_sbcount", SB_COUNT, 1);

        $display("[TB] reset mid-scrub with log entries");
        sbLow = 16'h0004; dbLow = 16'h0004;
        applyStimulus(14'd2, 14'd5);
        timedOut = 1'b1;
        for (int n = 0; n < 20; n++) begin
            if (LOG_VALID) begin
                timedOut = 1'b0;
                break;
            end
            tick();
        end
        checkOutput("rstm_logwait", timedOut, 0);
        checkOutput("rstm_prebusy", BUSY, 1);
        RST = 1'b1; START = 1'b1; ABORT = 1'b1; LOG_POP = 1'b1;
        ADDR_LO = 14'd0; ADDR_HI = 14'd3;
        tick();
        RST = 1'b0; START = 1'b0; ABORT = 1'b0; LOG_POP = 1'b0;
        checkOutput("rstm_busy",     BUSY,      0);
        checkOutput("rstm_logvalid", LOG_VALID, 0);
        checkOutput("rstm_logaddr",  LOG_ADDR,  0);
        checkOutput("rstm_sbcount",  SB_COUNT,  0);
        checkOutput("rstm_dbcount",  DB_COUNT,  0);
        checkOutput("rstm_ren",      R_EN,      0);

        $display("[TB] inverted range START ignored");
        applyStimulus(14'd9, 14'd2);
        checkOutput("inv_busy", BUSY, 0);
        repeat (4) tick();
        checkOutput("inv_busy_late", BUSY, 0);
        checkOutput("inv_nreads",    rAddrs.size(), 0);
        checkOutput("inv_ndone",     doneCount, 0);

        checkOutput("ren_wen_exclusive", bothSeen, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ecc_scrub_ctrl.md
ECC_SCRUB_CTRL -- requirements
Module: ecc_scrub_ctrl

Interface
REQ-001 Parameters SHALL be: ADDR_W, default 14, memory word address width; DATA_W, default 64, data word width; LOG_DEPTH, default 4, double-error log FIFO entries; CNT_W, default 16, error counter width.
REQ-002 Ports SHALL be (name  direction  width  meaning):
 CLK  in  1  single clock, all logic on rising edge
 RST  in  1  synchronous, active-high reset
 START  in  1  one-cycle scrub start request
 ABORT  in  1  stop the current scrub
 ADDR_LO  in  ADDR_W  first address of the scrub range
 ADDR_HI  in  ADDR_W  last address of the scrub range (inclusive)
 R_EN  out  1  memory read strobe
 R_ADDR  out  ADDR_W  memory read address
 RD_DATA  in  DATA_W  decoder-corrected read data, valid 1 cycle after R_EN
 SB_CORRECT  in  1  ECC flag, valid with RD_DATA
 DB_DETECT  in  1  ECC flag, valid with RD_DATA
 W_EN  out  1  memory write-back strobe
 W_ADDR  out  ADDR_W  write-back address
 W_DATA  out  DATA_W  write-back data
 BUSY  out  1  scrub in progress
 DONE  out  1  one-cycle completion pulse
 SB_COUNT  out  CNT_W  corrected-error count
 DB_COUNT  out  CNT_W  uncorrectable-error count
 LOG_VALID  out  1  log FIFO not empty
 LOG_ADDR  out  ADDR_W  oldest logged uncorrectable address
 LOG_POP  in  1  consume the log head
 LOG_OVF  out  1  sticky log-overflow flag

Function
REQ-003 The FSM SHALL have the states IDLE, READ, WAIT, CHECK, WRITE, NEXT and FIN.
REQ-004 In IDLE, START=1 with ADDR_LO<=ADDR_HI SHALL latch both bounds, set cur=ADDR_LO, clear SB_COUNT, DB_COUNT and LOG_OVF (the FIFO is not cleared), and enter READ.
REQ-005 START with ADDR_LO>ADDR_HI, and START outside IDLE, SHALL be ignored.
REQ-006 READ SHALL drive R_EN=1 with R_ADDR=cur for exactly one cycle, then enter WAIT.
REQ-007 WAIT SHALL register RD_DATA, SB_CORRECT and DB_DETECT, then enter CHECK.
REQ-008 CHECK classification: SB_CORRECT=1 with DB_DETECT=0 SHALL be treated as a single error: increment SB_COUNT, go to WRITE.
REQ-009 CHECK classification: SB_CORRECT=1 with DB_DETECT=1 SHALL be treated as a multiple error: increment DB_COUNT, push cur into the log, no write, go to NEXT.
REQ-010 CHECK classification: any other flag combination SHALL be treated as clean: go to NEXT.
REQ-011 WRITE SHALL drive W_EN=1, W_ADDR=cur and W_DATA=registered RD_DATA for exactly one cycle, then enter NEXT.
REQ-012 NEXT SHALL enter FIN if cur==latched ADDR_HI; otherwise it SHALL set cur=cur+1 and enter READ, so one address costs 4 cycles clean and 5 cycles with a write.
REQ-013 Address arithmetic SHALL be ADDR_W-bit; termination SHALL be by equality only, so ADDR_HI=2^ADDR_W-1 never wraps past the top.
REQ-014 FIN SHALL pulse DONE=1 for one cycle, then enter IDLE.
REQ-015 BUSY SHALL be 1 in every state except IDLE.
REQ-016 ABORT=1 in READ, WAIT, CHECK or NEXT SHALL enter IDLE on the next cycle with no DONE, and in-flight read data SHALL be discarded.
REQ-017 ABORT in WRITE SHALL let the write complete and then enter IDLE; ABORT in IDLE or FIN SHALL have no effect.
REQ-018 Counters SHALL saturate at 2^CNT_W-1.
REQ-019 The log SHALL be a FIFO of LOG_DEPTH entries; LOG_ADDR SHALL show the head combinationally from storage and is meaningful only while LOG_VALID=1.
REQ-020 LOG_POP while the log is empty SHALL be ignored.
REQ-021 A push while the log is full with no pop SHALL drop the new entry and set LOG_OVF; a push and a pop in the same cycle while full SHALL both succeed.
REQ-022 LOG_OVF SHALL stay set until RST or an accepted START.
REQ-023 R_EN and W_EN SHALL never both be 1 in the same cycle.

Reset
REQ-024 RST=1 SHALL, at the clock edge, force IDLE, empty the log, clear all counters and LOG_OVF, and drive R_EN, W_EN, BUSY, DONE and LOG_VALID to 0 with all address and data outputs at 0.
REQ-025 RST SHALL take priority over START, ABORT and LOG_POP, including mid-scrub and mid-write.

Verification
REQ-026 The bench SHALL cover: ADDR_LO=3, ADDR_HI=5, all reads clean -> R_EN pulses at addresses 3, 4, 5 four cycles apart, no W_EN, DONE 12 cycles after the first R_EN, SB_COUNT=DB_COUNT=0.
REQ-027 The bench SHALL cover: address 4 returns SB_CORRECT=1, DB_DETECT=0, RD_DATA=64'hA5A5 -> one W_EN with W_ADDR=4 and W_DATA=64'hA5A5, SB_COUNT=1.
REQ-028 The bench SHALL cover: addresses 1 through 6 all return SB_CORRECT=DB_DETECT=1 with no LOG_POP -> log holds 1, 2, 3, 4, LOG_OVF=1, DB_COUNT=6; four LOG_POPs then read back 1, 2, 3, 4.
REQ-029 The bench SHALL cover: ADDR_LO=ADDR_HI=14'h3FFF -> exactly one read, then DONE, with no wrap to address 0.
REQ-030 The bench SHALL cover: ABORT during WAIT -> IDLE next cycle, no DONE, no W_EN; ABORT during WRITE -> the write completes, then IDLE.
REQ-031 The bench SHALL cover: RST asserted mid-scrub while the log is non-empty -> next cycle BUSY=0, LOG_VALID=0, counters 0; START with ADDR_LO=9, ADDR_HI=2 -> ignored, BUSY stays 0.
